m31_mul_scheduler: RTL and testbench

//  Shares one pipelined Mersenne-31 (P = 2^31-1) modular multiplier between NUM_REQ requesters
//  (Monolith round lanes: S-box/MDS/round-constant units) using round-robin arbitration.

---
 rtl/m31_pkg.sv | 19 +
 rtl/m31_mul_scheduler_rr_arbiter.sv | 55 +++++
 rtl/m31_mul_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_m31_mul_scheduler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/m31_pkg.sv
// Mersenne-31 (P = 2^31-1) types and the single-fold reduction shared by every M31 multiplier.
package m31_pkg;

    typedef logic [30:0] m31_t;
    typedef logic [61:0] m31_prod_t;

    localparam m31_t M31_P = 31'h7FFF_FFFF;

    // Folding the 62b product once leaves r < 2P, so one conditional subtract makes it canonical.
    function automatic m31_t m31_reduce(input m31_prod_t prod);
        logic [31:0] r;
        r = {1'b0, prod[30:0]} + {1'b0, prod[61:31]};
        if (r >= {1'b0, M31_P}) begin
            r = r - {1'b0, M31_P};
        end
        return r[30:0];
    endfunction

endpackage

// File: rtl/m31_mul_scheduler_rr_arbiter.sv
// Round-robin arbiter: the pointer index has top priority, then ascending modulo N.
// The pointer moves to one past the winner whenever advance is asserted with a grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win;
    logic          found;

    // NOTE: every always_comb output gets a default before any branch; a path that skips an assignment would infer a latch.
    always_comb begin
        grant = '0;
        win   = ptr_q;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = PW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (win == PW'(N - 1)) ? '0 : win + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/m31_mul_scheduler.sv
// Shares one pipelined M31 multiplier among NUM_REQ round-robin requesters; results return tagged after MUL_LATENCY.
// Optional per-requester issue and contention counters are built when M31_MUL_STATS_EN is defined.
module m31_mul_scheduler
    import m31_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 3
`ifdef M31_MUL_STATS_EN
    ,
    parameter int STAT_W      = 32
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*31-1:0]   req_a,
    input  logic [NUM_REQ*31-1:0]   req_b,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [30:0]             rsp_data,
    output logic                    busy
`ifdef M31_MUL_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] stat_issued,
    output logic [STAT_W-1:0]         stat_contend
`endif
);

    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int LAST  = MUL_LATENCY - 1;

    logic [NUM_REQ-1:0] req_live;
    logic [NUM_REQ-1:0] grant;
    logic               issue;
    logic [TAG_W-1:0]   gnt_tag;
    m31_t               a_sel;
    m31_t               b_sel;

    // Requests are masked during reset so no handshake can occur on a reset edge.
    assign req_live = rst ? '0 : req_valid;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_live),
        .advance(|req_live),
        .grant  (grant)
    );

    assign req_ready = grant;
    assign issue     = |grant;

    always_comb begin
        gnt_tag = '0;
        a_sel   = '0;
        b_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_tag = TAG_W'(i);
                a_sel   = req_a[i*31 +: 31];
                b_sel   = req_b[i*31 +: 31];
            end
        end
    end

    logic [MUL_LATENCY-1:0] vld_q;
    logic [MUL_LATENCY-1:0] vld_d;
    logic [TAG_W-1:0]       tag_q [MUL_LATENCY];
    logic [TAG_W-1:0]       tag_d [MUL_LATENCY];

    always_comb begin
        vld_d[0] = issue;
        tag_d[0] = gnt_tag;
        for (int k = 1; k < MUL_LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            tag_d[k] = tag_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < MUL_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < MUL_LATENCY; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    m31_t result_d;
    m31_t rsp_data_q;

    generate
        if (MUL_LATENCY == 1) begin : g_lat1
            assign result_d = m31_reduce(m31_prod_t'(a_sel) * m31_prod_t'(b_sel));
        end else begin : g_latn
            m31_t op_a_q;
            m31_t op_b_q;

            // NOTE: datapath registers carry no reset; only the valid/tag chain needs a defined state, stale data is never presented.
            always_ff @(posedge clk) begin
                if (issue) begin
                    op_a_q <= a_sel;
                    op_b_q <= b_sel;
                end
            end

            if (MUL_LATENCY == 2) begin : g_lat2
                assign result_d = m31_reduce(m31_prod_t'(op_a_q) * m31_prod_t'(op_b_q));
            end else begin : g_lat3p
                localparam int PD = MUL_LATENCY - 2;
                m31_prod_t prod_q [PD];

                // Extra latency beyond three stages is absorbed by delaying the raw product.
                always_ff @(posedge clk) begin
                    if (vld_d[1]) begin
                        prod_q[0] <= m31_prod_t'(op_a_q) * m31_prod_t'(op_b_q);
                    end
                    for (int j = 1; j < PD; j++) begin
                        if (vld_d[j+1]) begin
                            prod_q[j] <= prod_q[j-1];
                        end
                    end
                end

                assign result_d = m31_reduce(prod_q[PD-1]);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_q <= '0;
        end else if (vld_d[LAST]) begin
            rsp_data_q <= result_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (vld_q[LAST]) begin
            rsp_valid[tag_q[LAST]] = 1'b1;
        end
    end

    assign rsp_data = rsp_data_q;
    assign busy     = |vld_q;

`ifdef M31_MUL_STATS_EN
    logic [STAT_W-1:0] stat_issued_q [NUM_REQ];
    logic [STAT_W-1:0] stat_contend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_issued_q[i] <= '0;
            end
            stat_contend_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    stat_issued_q[i] <= stat_issued_q[i] + 1'b1;
                end
            end
            if ($countones(req_valid) > 1) begin
                stat_contend_q <= stat_contend_q + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_issued[i*STAT_W +: STAT_W] = stat_issued_q[i];
        end
    end

    assign stat_contend = stat_contend_q;
`endif

endmodule

// File: tb/tb_m31_mul_scheduler.sv
// Randomized scoreboard bench for m31_mul_scheduler: the driver predicts grants and products, the monitor checks responses.
module tb_m31_mul_scheduler;
    import m31_pkg::*;

    localparam int   N   = 4;
    localparam int   LAT = 3;
    localparam int   SW  = 32;
    localparam m31_t P   = 31'h7FFF_FFFF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*31-1:0]   req_a = '0;
    logic [N*31-1:0]   req_b = '0;
    logic [N-1:0]      rsp_valid;
    logic [30:0]       rsp_data;
    logic              busy;
`ifdef M31_MUL_STATS_EN
    logic [N*SW-1:0]   stat_issued;
    logic [SW-1:0]     stat_contend;
`endif

    m31_mul_scheduler #(
        .NUM_REQ    (N),
        .MUL_LATENCY(LAT)
`ifdef M31_MUL_STATS_EN
        ,
        .STAT_W     (SW)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .busy        (busy)
`ifdef M31_MUL_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_contend(stat_contend)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   tag;
        m31_t data;
        int   due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   mdl_ptr = 0;
    int   mdl_iss [N];
    int   mdl_cont = 0;
    m31_t last_data = '0;
    m31_t ta [N];
    m31_t tbv [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Modular product straight from the definition, with wide integer arithmetic.
    function automatic m31_t ref_mul(input m31_t a, input m31_t b);
        logic [63:0] p;
        p = {33'b0, a} * {33'b0, b};
        return 31'(p % 64'h7FFF_FFFF);
    endfunction

    // Drive one cycle of requests, check the predicted grant and log the expected response.
    task automatic step(input logic [N-1:0] v, input logic r);
        logic [N-1:0] exp_g;
        int g;
        @(negedge clk);
        #2;
        rst       = r;
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_a[i*31 +: 31] = ta[i];
            req_b[i*31 +: 31] = tbv[i];
        end
        #1;
        exp_g = '0;
        g     = -1;
        if (!r) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && v[(mdl_ptr + k) % N]) g = (mdl_ptr + k) % N;
            end
        end
        if (g >= 0) exp_g[g] = 1'b1;
        check("req_ready", req_ready, exp_g);
        if (r) begin
            sb.delete();
            mdl_ptr   = 0;
            last_data = '0;
            mdl_cont  = 0;
            for (int i = 0; i < N; i++) mdl_iss[i] = 0;
        end else begin
            if (g >= 0) begin
                sb.push_back('{tag: g, data: ref_mul(ta[g], tbv[g]), due: cyc + LAT});
                mdl_ptr = (g + 1) % N;
                mdl_iss[g]++;
            end
            if ($countones(v) > 1) mdl_cont++;
        end
    endtask

    task automatic rand_ops();
        m31_t edge_vals [5];
        edge_vals = '{31'd0, 31'd1, P - 31'd1, P, 31'h4000_0000};
        for (int i = 0; i < N; i++) begin
            ta[i]  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : m31_t'($urandom() >> 1);
            tbv[i] = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : m31_t'($urandom() >> 1);
        end
    endtask

    logic         exp_busy;
    logic [N-1:0] exp_v;

    // Monitor: every cycle the response strobe, data and busy are compared against the scoreboard.
    always @(negedge clk) begin
        exp_busy = 1'b0;
        foreach (sb[i]) begin
            if (sb[i].due - LAT + 1 <= cyc) exp_busy = 1'b1;
        end
        check("busy", busy, exp_busy);
        exp_v = '0;
        if (sb.size() > 0 && sb[0].due == cyc) exp_v[sb[0].tag] = 1'b1;
        check("rsp_valid", rsp_valid, exp_v);
        if (exp_v != '0) begin
            check("rsp_data", rsp_data, sb[0].data);
            last_data = sb[0].data;
            void'(sb.pop_front());
        end else begin
            check("rsp_data_hold", rsp_data, last_data);
        end
    end

    initial begin
        m31_t bnd_a [5];
        m31_t bnd_b [5];
        bnd_a = '{P - 31'd1, 31'h4000_0000, 31'd0, P, P - 31'd1};
        bnd_b = '{P - 31'd1, 31'd2, 31'd12345, 31'd5, 31'd2};
        for (int i = 0; i < N; i++) begin
            ta[i] = '0; tbv[i] = '0; mdl_iss[i] = 0;
        end

        // Reset with every requester asserting valid: no grant may appear.
        repeat (3) step('1, 1'b1);

        // Single request from requester 0.
        while (cyc < 9) step('0, 1'b0);
        ta[0] = 31'd686829796; tbv[0] = 31'd742061112;
        step(4'b0001, 1'b0);
        repeat (LAT + 1) step('0, 1'b0);

        // Fresh pointer, all four contending for eight cycles.
        step('0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            rand_ops();
            step('1, 1'b0);
        end

        // Boundary operand pairs, each issued alone on a rotating requester.
        for (int i = 0; i < 5; i++) begin
            ta[i % N] = bnd_a[i]; tbv[i % N] = bnd_b[i];
            step(N'(1 << (i % N)), 1'b0);
        end
        repeat (LAT) step('0, 1'b0);

        // Requester 2 alone, then 1 and 3 together: 3 wins, then 1.
        rand_ops();
        step(4'b0100, 1'b0);
        step(4'b1010, 1'b0);
        step(4'b0010, 1'b0);
        repeat (LAT) step('0, 1'b0);

        // Reset while three operations are in flight.
        for (int c = 0; c < 3; c++) begin
            rand_ops();
            step('1, 1'b0);
        end
        step('0, 1'b1);
        rand_ops();
        step('1, 1'b0);
        repeat (LAT + 1) step('0, 1'b0);

        // Random traffic.
        for (int c = 0; c < 300; c++) begin
            rand_ops();
            step(N'($urandom_range(0, (1 << N) - 1)), 1'b0);
        end

        repeat (LAT + 2) step('0, 1'b0);
        check("scoreboard_drained", sb.size(), 0);

`ifdef M31_MUL_STATS_EN
        for (int i = 0; i < N; i++) begin
            check("stat_issued", stat_issued[i*SW +: SW], mdl_iss[i]);
        end
        check("stat_contend", stat_contend, mdl_cont);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
